cam_sequencer: RTL and testbench

//  Command-driven initiator for the cam array: accepts one host op at a time, expands it into

---
 rtl/cam_pkg.sv | 60 ++++++
 rtl/cam_write_encoder.sv | 21 ++
 rtl/cam_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_cam_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the cam sequencer and its host-side helpers:
// op encodings, FSM states, strobe kinds and small sizing/decode helpers.
package cam_pkg;

  // Host op encodings carried on cmd_op.
  localparam logic [2:0] OP_SET_ALL      = 3'd0;
  localparam logic [2:0] OP_SEARCH       = 3'd1;
  localparam logic [2:0] OP_SELECT_FIRST = 3'd2;
  localparam logic [2:0] OP_WRITE        = 3'd3;
  localparam logic [2:0] OP_READ         = 3'd4;

  // Sequencer phases.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // Which CAM strobe a step drives during its STROBE phase.
  typedef enum logic [2:0] {
    STB_NONE,
    STB_SET,
    STB_SEARCH,
    STB_SELECT,
    STB_WRITE
  } strobe_t;

  // Width of the shared phase down-counter.
  function automatic int cnt_width(input int pulse, input int settle);
    int longest;
    longest = (pulse > settle) ? pulse : settle;
    return $clog2(longest + 1);
  endfunction

  // Ops 5..7 have no meaning and are answered with an error response.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_READ);
  endfunction

  // SEARCH is the only two-step op (set, then perform_search).
  function automatic logic is_last_step(input logic [2:0] op, input logic step);
    return (op == OP_SEARCH) ? step : 1'b1;
  endfunction

  // Strobe driven by a given step of a given op.
  function automatic strobe_t step_strobe(input logic [2:0] op, input logic step);
    strobe_t kind;
    kind = STB_NONE;
    case (op)
      OP_SET_ALL:      kind = STB_SET;
      OP_SEARCH:       kind = step ? STB_SEARCH : STB_SET;
      OP_SELECT_FIRST: kind = STB_SELECT;
      OP_WRITE:        kind = STB_WRITE;
      default:         kind = STB_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/cam_write_encoder.sv
// Turns a value/enable-mask pair into the cam write_lines encoding:
// bit pair i is {clear, set}; an unmasked bit leaves both lines low.
module cam_write_encoder #(
  parameter int NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0]   data,
  input  logic [NUM_BITS-1:0]   mask,
  output logic [2*NUM_BITS-1:0] lines
);

  // Per-bit set/clear pair generation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lines = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      lines[2*i]   = data[i] & mask[i];
      lines[2*i+1] = ~data[i] & mask[i];
    end
  end

endmodule

// File: rtl/cam_sequencer.sv
// Command-driven initiator for the cam array. Accepts one host op at a
// time, expands it into timed strobe / settle phases on the cam inputs and
// returns a single response carrying read_lines and the tag summary.
module cam_sequencer
  import cam_pkg::*;
#(
  parameter int NUM_BITS      = 32,
  parameter int NUM_CELLS     = 100,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  // host command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [NUM_BITS-1:0]   cmd_data,
  input  logic [NUM_BITS-1:0]   cmd_mask,
  // host response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NUM_BITS-1:0]   rsp_data,
  output logic                  rsp_any,
  output logic                  rsp_err,
  // cam interface
  output logic [NUM_BITS-1:0]   comparand,
  output logic [NUM_BITS-1:0]   mask,
  output logic                  perform_search,
  output logic                  set,
  output logic                  select_first,
  output logic [2*NUM_BITS-1:0] write_lines,
  input  logic [NUM_CELLS-1:0]  tag_wires,
  input  logic [NUM_BITS-1:0]   read_lines
);

  localparam int            CW          = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  step_q, step_d;
  logic [2:0]            op_q;
  logic [NUM_BITS-1:0]   data_q, mask_q;
  logic                  accept;
  logic                  sample;

  // Op/operands as seen in the cycle being decoded: the live command on the
  // accept cycle, the latched copy afterwards.
  logic [2:0]            op_cur;
  logic [NUM_BITS-1:0]   data_cur, mask_cur;
  logic [2*NUM_BITS-1:0] enc_lines;
  strobe_t               strobe_d;

  assign op_cur   = accept ? cmd_op   : op_q;
  assign data_cur = accept ? cmd_data : data_q;
  assign mask_cur = accept ? cmd_mask : mask_q;

  // Handshake flags decode straight from the state register so reset
  // forces them immediately.
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  cam_write_encoder #(
    .NUM_BITS (NUM_BITS)
  ) u_write_encoder (
    .data  (data_cur),
    .mask  (mask_cur),
    .lines (enc_lines)
  );

  // Next-state, phase counter and step sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    accept  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          step_d = 1'b0;
          if (!op_legal(cmd_op)) begin
            state_d = ST_RESP;
            sample  = 1'b1;
          end else if (cmd_op == OP_READ) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = PULSE_LOAD;
          end
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          if (is_last_step(op_q, step_q)) begin
            state_d = ST_RESP;
            sample  = 1'b1;
          end else begin
            step_d  = 1'b1;
            state_d = ST_STROBE;
            cnt_d   = PULSE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe selected for the coming cycle; registering it keeps the cam
  // strobes glitch-free and aligned exactly with the STROBE phase.
  always_comb begin
    strobe_d = STB_NONE;
    if (state_d == ST_STROBE) begin
      strobe_d = step_strobe(op_cur, step_d);
    end
  end

  // FSM state, counter and latched command.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      op_q    <= OP_SET_ALL;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        mask_q <= cmd_mask;
      end
    end
  end

  // Comparand/mask load only on a SEARCH accept and hold otherwise so the
  // cam always sees stable search inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      comparand <= '0;
      mask      <= '0;
    end else if (accept && (cmd_op == OP_SEARCH)) begin
      comparand <= cmd_data;
      mask      <= cmd_mask;
    end
  end

  // Registered cam strobes and write pattern; at most one is ever active.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      set            <= 1'b0;
      perform_search <= 1'b0;
      select_first   <= 1'b0;
      write_lines    <= '0;
    end else begin
      set            <= (strobe_d == STB_SET);
      perform_search <= (strobe_d == STB_SEARCH);
      select_first   <= (strobe_d == STB_SELECT);
      write_lines    <= (strobe_d == STB_WRITE) ? enc_lines : '0;
    end
  end

  // Response capture on the last settle cycle (or at accept of an illegal op);
  // held unchanged while the host stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_data <= '0;
      rsp_any  <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (sample) begin
      rsp_err  <= !op_legal(op_cur);
      rsp_data <= op_legal(op_cur) ? read_lines : '0;
      rsp_any  <= op_legal(op_cur) ? (|tag_wires) : 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_sequencer.sv
// Self-checking bench for cam_sequencer driving a small behavioural cam
// (8 cells x 32 bits). Table-driven op vectors plus hand-written sequences
// for reset-in-flight, response back-pressure and strobe exclusivity.
module tb_cam_sequencer;
  import cam_pkg::*;

  localparam int NB = 32;
  localparam int NC = 8;
  localparam int P  = 2;
  localparam int S  = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            cmd_valid, cmd_ready;
  logic [2:0]      cmd_op;
  logic [NB-1:0]   cmd_data, cmd_mask;
  logic            rsp_valid, rsp_ready;
  logic [NB-1:0]   rsp_data;
  logic            rsp_any, rsp_err;
  logic [NB-1:0]   comparand, mask;
  logic            perform_search, set, select_first;
  logic [2*NB-1:0] write_lines;
  logic [NC-1:0]   tag_wires;
  logic [NB-1:0]   read_lines;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cam_sequencer #(
    .NUM_BITS      (NB),
    .NUM_CELLS     (NC),
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .cmd_mask       (cmd_mask),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_any        (rsp_any),
    .rsp_err        (rsp_err),
    .comparand      (comparand),
    .mask           (mask),
    .perform_search (perform_search),
    .set            (set),
    .select_first   (select_first),
    .write_lines    (write_lines),
    .tag_wires      (tag_wires),
    .read_lines     (read_lines)
  );

  // ---------------- behavioural cam ----------------
  logic [NB-1:0] cells [NC];
  logic [NC-1:0] tags;
  logic [NC-1:0] nt;
  logic [NB-1:0] w;
  logic          found;

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NC; i++) cells[i] = 32'h0100_0000 << i;
      tags = '0;
    end else if (set) begin
      tags = '1;
    end else if (perform_search) begin
      for (int i = 0; i < NC; i++)
        if (((cells[i] ^ comparand) & mask) != '0) tags[i] = 1'b0;
    end else if (select_first) begin
      nt = '0;
      found = 1'b0;
      for (int i = 0; i < NC; i++)
        if (tags[i] && !found) begin
          nt[i] = 1'b1;
          found = 1'b1;
        end
      tags = nt;
    end else if (write_lines != '0) begin
      for (int i = 0; i < NC; i++)
        if (tags[i]) begin
          w = cells[i];
          for (int b = 0; b < NB; b++) begin
            if (write_lines[2*b])   w[b] = 1'b1;
            if (write_lines[2*b+1]) w[b] = 1'b0;
          end
          cells[i] = w;
        end
    end
  end

  always_comb begin
    read_lines = '0;
    for (int i = 0; i < NC; i++)
      if (tags[i]) read_lines = read_lines | cells[i];
  end
  assign tag_wires = tags;

  // ---------------- strobe monitor ----------------
  int strobe_total = 0;
  int onehot_viol  = 0;

  always @(negedge CLK) begin
    int n;
    n = int'(set) + int'(perform_search) + int'(select_first) + int'(write_lines != '0);
    if (n > 0) strobe_total++;
    if (n > 1) onehot_viol++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] msk;
    logic [31:0] exp_data;
    logic        exp_any;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] d,
                              input logic [31:0] m, input logic [31:0] ed, input logic ea,
                              input logic ee);
    vec_t v;
    v.name = name; v.op = op; v.data = d; v.msk = m;
    v.exp_data = ed; v.exp_any = ea; v.exp_err = ee;
    return v;
  endfunction

  // Latency accept->rsp_valid and strobe-active cycles expected per op.
  function automatic int exp_latency(input logic [2:0] op);
    case (op)
      OP_SET_ALL, OP_SELECT_FIRST, OP_WRITE: return P + S + 1;
      OP_SEARCH:                             return 2 * (P + S) + 1;
      OP_READ:                               return S + 1;
      default:                               return 1;
    endcase
  endfunction

  function automatic int exp_strobes(input logic [2:0] op);
    case (op)
      OP_SET_ALL, OP_SELECT_FIRST, OP_WRITE: return P;
      OP_SEARCH:                             return 2 * P;
      default:                               return 0;
    endcase
  endfunction

  // Issue one op, measure latency, check response, optionally stall the
  // response for `hold` cycles, then complete the handshake.
  task automatic do_op(input vec_t v, input int hold);
    int lat, guard, s0;
    logic [31:0] d0;
    logic a0, e0, stable;
    guard = 0;
    @(negedge CLK);
    while (!cmd_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!cmd_ready) begin
      check({v.name, " cmd_ready timeout"}, 64'(cmd_ready), 64'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_mask  = v.msk;
    s0 = strobe_total;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    check({v.name, " latency"}, 64'(lat), 64'(exp_latency(v.op)));
    check({v.name, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
    check({v.name, " rsp_any"}, 64'(rsp_any), 64'(v.exp_any));
    check({v.name, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    check({v.name, " strobe cycles"}, 64'(strobe_total - s0), 64'(exp_strobes(v.op)));
    if (hold > 0) begin
      d0 = rsp_data; a0 = rsp_any; e0 = rsp_err; stable = 1'b1;
      repeat (hold) begin
        @(negedge CLK);
        if (rsp_data !== d0 || rsp_any !== a0 || rsp_err !== e0 || rsp_valid !== 1'b1 ||
            cmd_ready !== 1'b0)
          stable = 1'b0;
      end
      check({v.name, " stall stable"}, 64'(stable), 64'd1);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check({v.name, " post rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({v.name, " post cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset strobes", 64'({set, perform_search, select_first}), 64'd0);
    check("reset write_lines", 64'(write_lines), 64'd0);
    check("reset comparand/mask", {comparand, mask}, 64'd0);
    check("reset rsp fields", {rsp_data, 30'd0, rsp_any, rsp_err}, 64'd0);
    RST_N = 1'b1;

    // Reset asserted during the first STROBE cycle of a WRITE.
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 32'h5; cmd_mask = 32'hFF;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("midwrite lines active", 64'(write_lines != '0), 64'd1);
    RST_N = 1'b0;
    #1;
    check("midwrite reset write_lines", 64'(write_lines), 64'd0);
    check("midwrite reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("midwrite reset cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Vector table: cells start as 0x01000000<<i after reset.
    vecs.push_back(mk("set_all init", OP_SET_ALL, 0, 0, 32'hFF00_0000, 1, 0));
    vecs.push_back(mk("clear all", OP_WRITE, 0, 32'hFFFF_FFFF, 0, 1, 0));
    vecs.push_back(mk("search zero", OP_SEARCH, 0, 32'hFFFF_FFFF, 0, 1, 0));
    for (int k = 0; k < NC; k++) begin
      vecs.push_back(mk($sformatf("fill%0d search", k), OP_SEARCH, 0, 32'hFFFF_FFFF, 0, 1, 0));
      vecs.push_back(mk($sformatf("fill%0d select", k), OP_SELECT_FIRST, 0, 0, 0, 1, 0));
      vecs.push_back(mk($sformatf("fill%0d write", k), OP_WRITE, 32'(k + 1), 32'hFFFF_FFFF,
                        32'(k + 1), 1, 0));
    end
    vecs.push_back(mk("search 35", OP_SEARCH, 32'd35, 32'hFFFF_FFFF, 0, 0, 0));
    vecs.push_back(mk("search 5", OP_SEARCH, 32'd5, 32'hFFFF_FFFF, 32'd5, 1, 0));
    vecs.push_back(mk("search odd", OP_SEARCH, 32'd5, 32'h1, 32'd7, 1, 0));
    vecs.push_back(mk("select odd", OP_SELECT_FIRST, 0, 0, 32'd1, 1, 0));
    vecs.push_back(mk("read first", OP_READ, 0, 0, 32'd1, 1, 0));
    vecs.push_back(mk("write nibble", OP_WRITE, 32'h0000_00F0, 32'h0000_00FF, 32'hF0, 1, 0));
    vecs.push_back(mk("read nibble", OP_READ, 0, 0, 32'hF0, 1, 0));
    vecs.push_back(mk("illegal 5", 3'd5, 32'hDEAD, 32'hFFFF, 0, 0, 1));
    vecs.push_back(mk("illegal 6", 3'd6, 32'hBEEF, 32'hFFFF, 0, 0, 1));
    vecs.push_back(mk("illegal 7", 3'd7, 32'h1234, 32'hFFFF, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], 0);

    check("search zero tag count", 64'($countones(tag_wires)), 64'd1);

    // Comparand/mask keep the last SEARCH operands across WRITE/READ/illegal ops.
    check("comparand held", 64'(comparand), 64'd5);
    check("mask held", 64'(mask), 64'd1);

    // Back-pressure: response held 10 cycles; cells now F0,2..8.
    do_op(mk("stall set_all", OP_SET_ALL, 0, 0, 32'hFF, 1, 0), 10);

    check("strobe one-hot", 64'(onehot_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
